comparador_serial_ctrl: RTL and testbench

COMPARADOR_SERIAL_CTRL -- requirements
Module: comparador_serial_ctrl

---
 rtl/comparador_serial_ctrl_if.sv | 24 ++
 rtl/comparador_serial_ctrl.sv | 93 +++++++++
 tb/tb_comparador_serial_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/comparador_serial_ctrl_if.sv
// Handshake and result bundle for the serial magnitude comparator.
// The master drives the request and operands; the slave returns status and results.
interface comparador_serial_ctrl_if #(
    parameter int N = 8
);
    logic         start;
    logic [N-1:0] a_in;
    logic [N-1:0] b_in;
    logic         busy;
    logic         done;
    logic         gt;
    logic         lt;
    logic         eq;

    modport master (
        output start, a_in, b_in,
        input  busy, done, gt, lt, eq
    );

    modport slave (
        input  start, a_in, b_in,
        output busy, done, gt, lt, eq
    );
endinterface

// File: rtl/comparador_serial_ctrl.sv
// Bit-serial magnitude comparator: one comparator cell is applied MSB first
// over shifted copies of the operands, with optional early termination.
module comparador_serial_ctrl #(
    parameter int N          = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    comparador_serial_ctrl_if.slave bus
);
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t         state_reg, state_next;
    logic [N-1:0]   sa_reg, sb_reg;
    logic           x_reg, y_reg;
    logic [CW-1:0]  cnt_reg;
    logic           gt_reg, lt_reg, eq_reg;

    logic           a_bit, b_bit;
    logic           f_mid, g_mid;
    logic           finish;

    // (x,y) = 00 equal so far, 10 A greater, 01 A less; once set it sticks.
    assign a_bit  = sa_reg[N-1];
    assign b_bit  = sb_reg[N-1];
    assign f_mid  = x_reg | (~y_reg & a_bit & ~b_bit);
    assign g_mid  = y_reg | (~x_reg & ~a_bit & b_bit);
    assign finish = (cnt_reg == CW'(N - 1)) | (EARLY_EXIT & (f_mid | g_mid));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.start) state_next = SHIFT;
            SHIFT:   if (finish)    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            sa_reg    <= '0;
            sb_reg    <= '0;
            x_reg     <= 1'b0;
            y_reg     <= 1'b0;
            cnt_reg   <= '0;
            gt_reg    <= 1'b0;
            lt_reg    <= 1'b0;
            eq_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        sa_reg  <= bus.a_in;
                        sb_reg  <= bus.b_in;
                        x_reg   <= 1'b0;
                        y_reg   <= 1'b0;
                        cnt_reg <= '0;
                    end
                end
                SHIFT: begin
                    x_reg   <= f_mid;
                    y_reg   <= g_mid;
                    sa_reg  <= {sa_reg[N-2:0], 1'b0};
                    sb_reg  <= {sb_reg[N-2:0], 1'b0};
                    // Counter stops at N-1; the FSM leaves SHIFT on that edge.
                    if (!finish) cnt_reg <= cnt_reg + CW'(1);
                    if (finish) begin
                        gt_reg <= f_mid;
                        lt_reg <= g_mid;
                        eq_reg <= ~(f_mid | g_mid);
                    end
                end
                default: ;
            endcase
        end
    end

    // Status comes straight from the state register so it cannot glitch.
    assign bus.busy = (state_reg == SHIFT);
    assign bus.done = (state_reg == DONE);
    assign bus.gt   = gt_reg;
    assign bus.lt   = lt_reg;
    assign bus.eq   = eq_reg;
endmodule

// File: tb/tb_comparador_serial_ctrl.sv
// Scoreboard bench: four comparator instances (N=8/2, EARLY_EXIT=0/1) checked
// against an integer-comparison model with expected done timing.
module tb_comparador_serial_ctrl;
    logic clk;
    logic rst;

    logic        start_s [4];
    logic [31:0] a_s     [4];
    logic [31:0] b_s     [4];
    logic        busy_s  [4];
    logic        done_s  [4];
    logic        gt_s    [4];
    logic        lt_s    [4];
    logic        eq_s    [4];

    longint cyc;
    int     n_checks;
    int     n_fail;

    typedef struct {
        int          ch;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  res;
        longint      done_cyc;
    } exp_t;

    exp_t exp_q[$];

    // Channel 0/1: N=8, channel 2/3: N=2; even channels without early exit.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_ch
            localparam int NN = (gi < 2) ? 8 : 2;
            localparam bit EE = (gi % 2) == 1;
            comparador_serial_ctrl_if #(.N(NN)) bus_if ();
            assign bus_if.start = start_s[gi];
            assign bus_if.a_in  = a_s[gi][NN-1:0];
            assign bus_if.b_in  = b_s[gi][NN-1:0];
            assign busy_s[gi]   = bus_if.busy;
            assign done_s[gi]   = bus_if.done;
            assign gt_s[gi]     = bus_if.gt;
            assign lt_s[gi]     = bus_if.lt;
            assign eq_s[gi]     = bus_if.eq;
            comparador_serial_ctrl #(.N(NN), .EARLY_EXIT(EE)) dut (
                .clk (clk),
                .rst (rst),
                .bus (bus_if)
            );
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int chan_n(input int ch);
        return (ch < 2) ? 8 : 2;
    endfunction

    function automatic bit chan_ee(input int ch);
        return (ch % 2) == 1;
    endfunction

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Reference: plain integer comparison; latency is N, or the 1-based MSB
    // position of the first differing bit when early exit is enabled.
    function automatic exp_t model(input int ch, input logic [31:0] a, input logic [31:0] b,
                                   input longint issue_cyc);
        exp_t        e;
        int          n;
        int          lat;
        logic [31:0] d;
        n   = chan_n(ch);
        lat = n;
        d   = a ^ b;
        if (chan_ee(ch) && d != 0) begin
            for (int i = n - 1; i >= 0; i--) begin
                if (d[i]) begin
                    lat = n - i;
                    break;
                end
            end
        end
        e.ch       = ch;
        e.a        = a;
        e.b        = b;
        e.res      = {a > b, a < b, a == b};
        e.done_cyc = issue_cyc + 1 + lat;
        return e;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        for (int ch = 0; ch < 4; ch++) begin
            if (done_s[ch]) begin
                if (exp_q.size() == 0) begin
                    check($sformatf("unexpected_done_ch%0d", ch), 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    $display("cmp ch%0d a=%h b=%h gt=%b lt=%b eq=%b cyc=%0d",
                             ch, e.a, e.b, gt_s[ch], lt_s[ch], eq_s[ch], cyc);
                    check("done_channel", ch, e.ch);
                    check("result_gt_lt_eq", {gt_s[ch], lt_s[ch], eq_s[ch]}, e.res);
                    check("done_cycle", cyc, e.done_cyc);
                    check("onehot", $countones({gt_s[ch], lt_s[ch], eq_s[ch]}), 1);
                    check("busy_in_done", busy_s[ch], 0);
                end
            end
        end
    end

    task automatic drain(input int bound);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < bound) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (exp_q.size() != 0) begin
            check("timeout_waiting_done", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic run_cmp(input int ch, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] mask;
        mask = (32'h1 << chan_n(ch)) - 32'h1;
        @(negedge clk);
        exp_q.push_back(model(ch, a & mask, b & mask, cyc));
        start_s[ch] = 1'b1;
        a_s[ch]     = a & mask;
        b_s[ch]     = b & mask;
        @(negedge clk);
        start_s[ch] = 1'b0;
        drain(40);
    endtask

    initial begin : stim
        longint c0;
        logic [31:0] ra, rb;
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        rst      = 1'b1;
        for (int ch = 0; ch < 4; ch++) begin
            start_s[ch] = 1'b0;
            a_s[ch]     = '0;
            b_s[ch]     = '0;
        end
        repeat (3) @(negedge clk);
        for (int ch = 0; ch < 4; ch++) begin
            check("reset_busy", busy_s[ch], 0);
            check("reset_done", done_s[ch], 0);
            check("reset_results", {gt_s[ch], lt_s[ch], eq_s[ch]}, 3'b000);
        end
        rst = 1'b0;

        // Directed cases.
        run_cmp(0, 32'hA5, 32'hA5);
        run_cmp(1, 32'h80, 32'h7F);
        run_cmp(1, 32'h12, 32'h13);
        run_cmp(0, 32'h00, 32'hFF);
        run_cmp(1, 32'hFF, 32'hFE);

        // start held during SHIFT with new operands: first result unaffected,
        // second accepted only from IDLE after DONE.
        @(negedge clk);
        c0 = cyc;
        exp_q.push_back(model(0, 32'h10, 32'h20, c0));
        exp_q.push_back(model(0, 32'hF0, 32'h01, c0 + 10));
        start_s[0] = 1'b1;
        a_s[0]     = 32'h10;
        b_s[0]     = 32'h20;
        @(negedge clk);
        a_s[0] = 32'hF0;
        b_s[0] = 32'h01;
        while (cyc < c0 + 11) @(negedge clk);
        check("second_accepted_busy", busy_s[0], 1);
        check("results_held_in_shift", {gt_s[0], lt_s[0], eq_s[0]}, 3'b010);
        start_s[0] = 1'b0;
        drain(40);

        // Asynchronous reset in the middle of SHIFT aborts the comparison.
        @(negedge clk);
        start_s[0] = 1'b1;
        a_s[0]     = 32'h12;
        b_s[0]     = 32'h34;
        @(negedge clk);
        start_s[0] = 1'b0;
        repeat (2) @(negedge clk);
        check("busy_before_abort", busy_s[0], 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_busy_immediate", busy_s[0], 0);
        check("abort_done", done_s[0], 0);
        check("abort_results", {gt_s[0], lt_s[0], eq_s[0]}, 3'b000);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("abort_results_after", {gt_s[0], lt_s[0], eq_s[0]}, 3'b000);
        run_cmp(0, 32'h01, 32'h00);

        // Exhaustive N=2, both early-exit settings.
        for (int ch = 2; ch < 4; ch++)
            for (int a = 0; a < 4; a++)
                for (int b = 0; b < 4; b++)
                    run_cmp(ch, a, b);

        // Randomized N=8, half the pairs differing in a single bit.
        for (int i = 0; i < 60; i++) begin
            ra = $urandom_range(0, 255);
            if ($urandom_range(0, 1) == 1) rb = ra ^ (32'h1 << $urandom_range(0, 7));
            else if ($urandom_range(0, 7) == 0) rb = ra;
            else rb = $urandom_range(0, 255);
            run_cmp(i % 2, ra, rb);
        end

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
